alu_issue_capture: RTL and testbench

//  Sequencer wrapped around the gate-delay 32-bit ALU. Accepts one operation per

---
 rtl/alu_issue_capture.sv | 109 ++++++++++
 tb/tb_alu_issue_capture.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_capture.sv
// Issue/capture sequencer around a gate-delay ALU: launch operands, wait SETTLE_CYCLES edges, capture result+flags.
// Latency SETTLE_CYCLES edges accept->out_valid; one op in flight, in_ready low until the result handshake completes.
// Optional feature macro: STICKY_OVF_EN (sticky overflow flag with clear input).
module alu_issue_capture #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef STICKY_OVF_EN
    input  logic             clr_sticky,
    output logic             sticky_ovf,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_carryout,
    input  logic             alu_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_zero
);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt;
    logic       accept, capture, done_hs;
    logic       logic_op, carry_m, ovf_m;

    assign accept   = in_valid && in_ready;
    assign capture  = (state == SETTLE) && (cnt == 8'd0);
    assign done_hs  = out_valid && out_ready;
    // Carry/overflow are meaningless for bitwise ops (op >= 2), whatever the ALU pins say.
    assign logic_op = alu_op[2] | alu_op[1];
    assign carry_m  = alu_carryout & ~logic_op;
    assign ovf_m    = alu_overflow & ~logic_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)  state_nxt = SETTLE;
            SETTLE:  if (capture) state_nxt = HOLD;
            HOLD:    if (done_hs) state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 8'd0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= 3'd0;
        end else if (accept) begin
            cnt    <= CNT_INIT;
            alu_a  <= in_a;
            alu_b  <= in_b;
            alu_op <= in_op;
        end else if (state == SETTLE && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_res      <= '0;
            out_carry    <= 1'b0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
        end else if (capture) begin
            out_res      <= alu_res;
            out_carry    <= carry_m;
            out_overflow <= ovf_m;
            out_zero     <= (alu_res == '0);
        end
    end

`ifdef STICKY_OVF_EN
    // A capture that overflows beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 sticky_ovf <= 1'b0;
        else if (capture && ovf_m)  sticky_ovf <= 1'b1;
        else if (clr_sticky)        sticky_ovf <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_alu_issue_capture.sv
// Directed bench for alu_issue_capture: table of ALU ops plus hold, reset-abort, SETTLE=1 and sticky sequences.
module tb_alu_issue_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_a = '0, in_b = '0;
    logic [2:0]  in_op = '0;
    logic        in_ready, out_valid;
    logic [31:0] alu_a, alu_b, alu_res, out_res;
    logic [2:0]  alu_op;
    logic        alu_carryout, alu_overflow;
    logic        out_carry, out_overflow, out_zero;
    logic        force_flags = 1'b0;
`ifdef STICKY_OVF_EN
    logic        clr_sticky = 1'b0;
    logic        sticky_ovf;
`endif

    // SETTLE_CYCLES=1 instance
    logic        s1_in_valid = 1'b0, s1_out_ready = 1'b0;
    logic [31:0] s1_in_a = '0, s1_in_b = '0;
    logic        s1_in_ready, s1_out_valid, s1_carry, s1_ovf, s1_zero;
    logic [31:0] s1_alu_a, s1_alu_b, s1_res;
    logic [2:0]  s1_alu_op;
`ifdef STICKY_OVF_EN
    logic        s1_sticky;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_issue_capture #(.WIDTH(32), .SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef STICKY_OVF_EN
        .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_res(alu_res), .alu_carryout(alu_carryout), .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_carry(out_carry), .out_overflow(out_overflow), .out_zero(out_zero)
    );

    alu_issue_capture #(.WIDTH(32), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
`ifdef STICKY_OVF_EN
        .clr_sticky(1'b0), .sticky_ovf(s1_sticky),
`endif
        .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_a(s1_in_a), .in_b(s1_in_b), .in_op(3'd0),
        .alu_a(s1_alu_a), .alu_b(s1_alu_b), .alu_op(s1_alu_op),
        .alu_res(s1_alu_a + s1_alu_b), .alu_carryout(1'b0), .alu_overflow(1'b0),
        .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_res(s1_res),
        .out_carry(s1_carry), .out_overflow(s1_ovf), .out_zero(s1_zero)
    );

    // Behavioural ALU driven from the registered operands; force_flags drives both flag pins high.
    always_comb begin
        logic [32:0] sum;
        sum          = '0;
        alu_res      = '0;
        alu_carryout = 1'b0;
        alu_overflow = 1'b0;
        case (alu_op)
            3'd0: begin
                sum          = {1'b0, alu_a} + {1'b0, alu_b};
                alu_res      = sum[31:0];
                alu_carryout = sum[32];
                alu_overflow = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
            end
            3'd1: begin
                sum          = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_res      = sum[31:0];
                alu_carryout = sum[32];
                alu_overflow = (alu_a[31] != alu_b[31]) && (sum[31] != alu_a[31]);
            end
            3'd2:    alu_res = alu_a ^ alu_b;
            3'd3:    alu_res = alu_a & alu_b;
            3'd4:    alu_res = ~(alu_a & alu_b);
            3'd5:    alu_res = alu_a | alu_b;
            3'd6:    alu_res = ~(alu_a | alu_b);
            default: alu_res = ~alu_a;
        endcase
        if (force_flags) begin
            alu_carryout = 1'b1;
            alu_overflow = 1'b1;
        end
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        ff;
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        z;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_op(input vec_t v, input int idx, input int hold);
        int          n;
        logic        bad;
        logic [31:0] r;
        force_flags = v.ff;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check($sformatf("v%0d_in_ready_idle", idx), {31'd0, in_ready}, 32'd1);
        in_a = v.a; in_b = v.b; in_op = v.op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = ~v.a; in_b = ~v.b; in_op = ~v.op;
        check($sformatf("v%0d_alu_a", idx), alu_a, v.a);
        check($sformatf("v%0d_alu_op", idx), {29'd0, alu_op}, {29'd0, v.op});
        check($sformatf("v%0d_in_ready_busy", idx), {31'd0, in_ready}, 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check($sformatf("v%0d_latency", idx), n, 32'd4);
        check($sformatf("v%0d_res", idx), out_res, v.res);
        check($sformatf("v%0d_carry", idx), {31'd0, out_carry}, {31'd0, v.c});
        check($sformatf("v%0d_ovf", idx), {31'd0, out_overflow}, {31'd0, v.v});
        check($sformatf("v%0d_zero", idx), {31'd0, out_zero}, {31'd0, v.z});
        check($sformatf("v%0d_in_ready_hold", idx), {31'd0, in_ready}, 32'd0);
        r   = out_res;
        bad = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            if (out_res !== r || alu_a !== v.a || alu_b !== v.b || in_ready !== 1'b0 || out_valid !== 1'b1)
                bad = 1'b1;
        end
        if (hold > 0) check($sformatf("v%0d_hold_stable", idx), {31'd0, bad}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check($sformatf("v%0d_valid_drop", idx), {31'd0, out_valid}, 32'd0);
        check($sformatf("v%0d_ready_back", idx), {31'd0, in_ready}, 32'd1);
        check($sformatf("v%0d_res_kept", idx), out_res, v.res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[11];
        tbl[0]  = '{3'd0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{3'd1, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{3'd3, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'hF000F000, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{3'd0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{3'd1, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{3'd1, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{3'd2, 32'hAAAAAAAA, 32'h55555555, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{3'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{3'd5, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{3'd6, 32'h00000000, 32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{3'd7, 32'h12345678, 32'hDEADBEEF, 1'b1, 32'hEDCBA987, 1'b0, 1'b0, 1'b0};

        // Reset state
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_out_res", out_res, 32'd0);
        check("rst_flags", {28'd0, out_carry, out_overflow, out_zero, alu_op[0]}, 32'd0);
`ifdef STICKY_OVF_EN
        check("rst_sticky", {31'd0, sticky_ovf}, 32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) do_op(tbl[i], i, 0);

        // Long HOLD backpressure, then back-to-back acceptance
        do_op(tbl[0], 100, 10);
        do_op(tbl[1], 101, 0);

        // Reset two cycles into SETTLE aborts the op
        do_op(tbl[0], 102, 0);
        in_a = 32'h11111111; in_b = 32'h22222222; in_op = 3'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_alu_a", alu_a, 32'd0);
        check("abort_out_res", out_res, 32'd0);
        check("abort_out_ovf", {31'd0, out_overflow}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_still_idle", {30'd0, out_valid, in_ready}, 32'd1);
        do_op(tbl[2], 103, 0);

        // SETTLE_CYCLES=1: capture on the edge right after acceptance
        s1_in_a = 32'd3; s1_in_b = 32'd4; s1_in_valid = 1'b1;
        @(posedge clk); #1;
        s1_in_valid = 1'b0;
        check("s1_not_yet_valid", {31'd0, s1_out_valid}, 32'd0);
        @(posedge clk); #1;
        check("s1_valid", {31'd0, s1_out_valid}, 32'd1);
        check("s1_res", s1_res, 32'd7);
        s1_out_ready = 1'b1;
        @(posedge clk); #1;
        s1_out_ready = 1'b0;
        check("s1_ready_back", {31'd0, s1_in_ready}, 32'd1);

`ifdef STICKY_OVF_EN
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        check("sticky_cleared0", {31'd0, sticky_ovf}, 32'd0);
        do_op(tbl[0], 200, 0);
        check("sticky_set", {31'd0, sticky_ovf}, 32'd1);
        do_op('{3'd0, 32'd1, 32'd1, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0}, 201, 0);
        check("sticky_held", {31'd0, sticky_ovf}, 32'd1);
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        check("sticky_cleared", {31'd0, sticky_ovf}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
